flp_dec_bcd_conv: RTL and testbench
===================================

Name: flp_dec_bcd_conv

Overview:
- Sequential decimal-digit formatter that sits directly downstream of the float-to-decimal stage.
- Takes its binary integer part (24 bit), binary fraction (24 bit) and sign, and produces packed BCD digits for a display or UART formatter.
- Integer part: double-dabble, one bit per cycle. Fraction: repeated multiply-by-10, one digit per cycle. Both run concurrently under one FSM with valid/ready handshakes on both sides.

Parameters:
- N_FRAC, 6, number of fractional decimal digits produced; legal range 1..24.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents a value
- in_ready  out  1  block can accept a value (high only in IDLE)
- sign_in  in  1  sign of the value
- int_in  in  24  unsigned binary integer part
- frac_in  in  24  binary fraction; value = frac_in * 2^-24, MSB weight 0.5
- out_valid  out  1  result registers hold a finished conversion
- out_ready  in  1  downstream accepts result
- sign_out  out  1  registered copy of sign_in
- int_bcd  out  32  8 BCD digits of int_in, digit 7 at [31:28]
- frac_bcd  out  4*N_FRAC  fraction digits, tenths digit at MSB nibble
- busy  out  1  high in CONV

Behaviour:
- Reset (async, rst_n=0) drives the following. Deassertion takes effect on the next clk edge.
  - state=IDLE; in_ready=1; out_valid=0; busy=0
  - sign_out=0; int_bcd=0; frac_bcd=0; all internal shift/frac/counter registers 0
- FSM states are IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0: load bin_sh<=int_in, bcd_acc<=0, frac_acc<=frac_in, sign_out<=sign_in, cnt<=0, frac_bcd<=0; go to CONV.
- CONV, edges E1..E24 (one step per edge):
  - Integer step: every nibble of bcd_acc >=5 gets +3 (all nibbles corrected in parallel). Then {bcd_acc,bin_sh} shifts left by 1.
  - Fraction step, only when cnt<N_FRAC: p = frac_acc*10 computed as (frac_acc<<3)+(frac_acc<<1), 28-bit result.
    - Digit = p[27:24] (always 0..9), written into nibble N_FRAC-1-cnt of frac_bcd.
    - frac_acc <= p[23:0].
  - cnt increments each edge. At the edge where cnt==23, copy int_bcd<=corrected/shifted bcd_acc and go to DONE.
- Latency: out_valid rises exactly 24 clk cycles after the input-handshake edge.
- DONE:
  - out_valid=1; outputs stable.
  - On out_ready at an edge: out_valid<=0, go to IDLE. Output registers keep their values until the next load.
- in_ready=0 in CONV and DONE. No input overlap; max throughput is 1 result per 26 cycles, plus any out_ready stall.
- Fraction rounding: truncation only, no rounding. frac_in=0 yields all-zero digits.
- sign passes through untouched; the block never negates values. A negative zero is reported as sign_out=1 with zero digits.
- int_in max 16777215 fits 8 digits; no overflow is possible.
- out_ready asserted while not in DONE is ignored. in_valid while not in IDLE is ignored; upstream must hold the value.
- Reset asserted during CONV or DONE aborts immediately to reset values. A partial result is never presented.

Decomposition:
- Package flp_dec_pkg:
  - INT_W=24, INT_DIGITS=8, CONV_STEPS=24
  - state encoding IDLE=2'd0, CONV=2'd1, DONE=2'd2
- Sub-module dd_step: combinational. Takes a 32-bit BCD accumulator plus the incoming bit and returns the add-3-corrected, shifted accumulator. Contains 8 nibble add-3 cells.
- The frac multiply-by-10 stays inline.

Test Plan:
- Reset, then int_in=12345, frac_in=24'h800000, sign_in=0, in_valid 1 cycle -> 24 cycles later out_valid=1, int_bcd=32'h00012345, frac_bcd=24'h500000, sign_out=0.
- int_in=16777215, frac_in=24'hFFFFFF, sign_in=1 -> int_bcd=32'h16777215, frac_bcd=24'h999999, sign_out=1.
- int_in=0, frac_in=24'h400000 -> int_bcd=0, frac_bcd=24'h250000. Then frac_in=24'h000001 -> frac_bcd=24'h000000 (truncation).
- Hold out_ready=0 for 10 cycles after done -> out_valid and outputs stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 at cycle 10 of CONV -> out_valid=0, busy=0, int_bcd=0 immediately. New conversion of int_in=99 afterwards -> int_bcd=32'h00000099.
- N_FRAC=1 instance, frac_in=24'hE66666 (~0.9) -> frac_bcd=4'h8 (0.89999), latency still 24.

Source files
------------

// File: rtl/flp_dec_pkg.sv
// Shared widths, step count and FSM state type for the decimal/BCD formatter.
package flp_dec_pkg;

  localparam int unsigned INT_W      = 24;
  localparam int unsigned INT_DIGITS = 8;
  localparam int unsigned CONV_STEPS = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/flp_dec_bcd_conv_dd_step.sv
// One double-dabble step: add-3 correction on every BCD nibble, then shift in one bit.
module dd_step
  import flp_dec_pkg::*;
(
  input  logic [4*INT_DIGITS-1:0] acc,
  input  logic                    bit_in,
  output logic [4*INT_DIGITS-1:0] acc_next
);

  logic [4*INT_DIGITS-1:0] corr;

  // Correct all nibbles in parallel, then shift the accumulator left by one.
  always_comb begin
    corr = '0;
    for (int unsigned i = 0; i < INT_DIGITS; i++) begin
      corr[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    acc_next = {corr[4*INT_DIGITS-2:0], bit_in};
  end

endmodule

// File: rtl/flp_dec_bcd_conv.sv
// Binary integer/fraction to packed BCD formatter: double-dabble for the
// integer part and multiply-by-10 for the fraction, running side by side.
module flp_dec_bcd_conv
  import flp_dec_pkg::*;
#(
  parameter int unsigned N_FRAC = 6
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign_in,
  input  logic [INT_W-1:0]        int_in,
  input  logic [INT_W-1:0]        frac_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_out,
  output logic [4*INT_DIGITS-1:0] int_bcd,
  output logic [4*N_FRAC-1:0]     frac_bcd,
  output logic                    busy
);

  localparam logic [4:0] LAST_STEP = 5'(CONV_STEPS - 1);
  localparam logic [4:0] NF        = 5'(N_FRAC);
  localparam logic [4:0] NF_LAST   = 5'(N_FRAC - 1);

  state_t                  state, state_next;
  logic [INT_W-1:0]        bin_sh;
  logic [4*INT_DIGITS-1:0] bcd_acc;
  logic [4*INT_DIGITS-1:0] dd_next;
  logic [INT_W-1:0]        frac_acc;
  logic [4:0]              cnt;
  logic [INT_W+3:0]        prod;
  logic [4*N_FRAC-1:0]     frac_bcd_next;

  dd_step u_dd_step (
    .acc      (bcd_acc),
    .bit_in   (bin_sh[INT_W-1]),
    .acc_next (dd_next)
  );

  // Fraction times ten; the overflow nibble is the next decimal digit.
  always_comb begin
    prod = {1'b0, frac_acc, 3'b000} + {3'b000, frac_acc, 1'b0};
    frac_bcd_next = frac_bcd;
    for (int unsigned i = 0; i < N_FRAC; i++) begin
      if (cnt == NF_LAST - 5'(i)) begin
        frac_bcd_next[4*i +: 4] = prod[INT_W+3:INT_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = CONV;
      CONV:    if (cnt == LAST_STEP)  state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == CONV);
    out_valid = (state == DONE);
  end

  // Datapath: load on accept, one integer bit and (while digits remain) one fraction digit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sh   <= '0;
      bcd_acc  <= '0;
      frac_acc <= '0;
      cnt      <= '0;
      sign_out <= 1'b0;
      int_bcd  <= '0;
      frac_bcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sh   <= int_in;
            bcd_acc  <= '0;
            frac_acc <= frac_in;
            sign_out <= sign_in;
            cnt      <= '0;
            frac_bcd <= '0;
          end
        end
        CONV: begin
          bin_sh  <= {bin_sh[INT_W-2:0], 1'b0};
          bcd_acc <= dd_next;
          if (cnt < NF) begin
            frac_acc <= prod[INT_W-1:0];
            frac_bcd <= frac_bcd_next;
          end
          cnt <= cnt + 5'd1;
          if (cnt == LAST_STEP) int_bcd <= dd_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flp_dec_bcd_conv.sv
// Directed bench for flp_dec_bcd_conv: table of conversions plus stall,
// mid-conversion reset and a single-fraction-digit instance.
module tb_flp_dec_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sign_in, out_valid, out_ready, sign_out, busy;
  logic [23:0] int_in, frac_in;
  logic [31:0] int_bcd;
  logic [23:0] frac_bcd;

  logic        in_valid_1, in_ready_1, sign_in_1, out_valid_1, out_ready_1, sign_out_1, busy_1;
  logic [23:0] int_in_1, frac_in_1;
  logic [31:0] int_bcd_1;
  logic [3:0]  frac_bcd_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flp_dec_bcd_conv #(.N_FRAC(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .int_in(int_in), .frac_in(frac_in),
    .out_valid(out_valid), .out_ready(out_ready), .sign_out(sign_out),
    .int_bcd(int_bcd), .frac_bcd(frac_bcd), .busy(busy)
  );

  flp_dec_bcd_conv #(.N_FRAC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .sign_in(sign_in_1), .int_in(int_in_1), .frac_in(frac_in_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .sign_out(sign_out_1),
    .int_bcd(int_bcd_1), .frac_bcd(frac_bcd_1), .busy(busy_1)
  );

  typedef struct {
    logic        s;
    logic [23:0] i;
    logic [23:0] f;
    logic [31:0] exp_int;
    logic [23:0] exp_frac;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Start a conversion on the main instance and wait (bounded) for out_valid.
  task automatic convert(input logic s, input logic [23:0] i, input logic [23:0] f);
    int cyc;
    @(negedge clk);
    check("in_ready_before", 32'(in_ready), 32'd1);
    sign_in = s; int_in = i; frac_in = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_conv", 32'(busy), 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd24);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    vecs[0] = '{1'b0, 24'd12345,    24'h800000, 32'h00012345, 24'h500000};
    vecs[1] = '{1'b1, 24'd16777215, 24'hFFFFFF, 32'h16777215, 24'h999999};
    vecs[2] = '{1'b0, 24'd0,        24'h400000, 32'h00000000, 24'h250000};
    vecs[3] = '{1'b0, 24'd0,        24'h000001, 32'h00000000, 24'h000000};
    vecs[4] = '{1'b1, 24'd0,        24'h000000, 32'h00000000, 24'h000000};
    vecs[5] = '{1'b0, 24'd9,        24'h19999A, 32'h00000009, 24'h100000};
    vecs[6] = '{1'b0, 24'd10000000, 24'hC00000, 32'h10000000, 24'h750000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sign_in = 1'b0; int_in = '0; frac_in = '0;
    in_valid_1 = 1'b0; out_ready_1 = 1'b0; sign_in_1 = 1'b0; int_in_1 = '0; frac_in_1 = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_int_bcd", int_bcd, 32'd0);
    check("rst_frac_bcd", 32'(frac_bcd), 32'd0);
    check("rst_sign_out", 32'(sign_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      convert(vecs[k].s, vecs[k].i, vecs[k].f);
      check("int_bcd", int_bcd, vecs[k].exp_int);
      check("frac_bcd", 32'(frac_bcd), 32'(vecs[k].exp_frac));
      check("sign_out", 32'(sign_out), 32'(vecs[k].s));
      release_result();
    end

    // Downstream stall: result held, new input ignored.
    convert(1'b0, 24'd4321, 24'h800000);
    @(negedge clk);
    sign_in = 1'b1; int_in = 24'd777; frac_in = 24'h400000; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_int_bcd", int_bcd, 32'h00004321);
      check("stall_frac_bcd", 32'(frac_bcd), 32'h500000);
      check("stall_sign", 32'(sign_out), 32'd0);
    end
    @(negedge clk); in_valid = 1'b0;
    release_result();
    check("post_stall_busy", 32'(busy), 32'd0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    sign_in = 1'b1; int_in = 24'd12345; frac_in = 24'h800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_int_bcd", int_bcd, 32'd0);
    check("abort_sign", 32'(sign_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    convert(1'b0, 24'd99, 24'h000000);
    check("after_abort_int", int_bcd, 32'h00000099);
    release_result();

    // Single fraction digit instance.
    @(negedge clk);
    int_in_1 = 24'd7; frac_in_1 = 24'hE66666; in_valid_1 = 1'b1;
    @(posedge clk); #1;
    in_valid_1 = 1'b0;
    cyc = 0;
    while (!out_valid_1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("n1_latency", 32'(cyc), 32'd24);
    check("n1_frac_bcd", 32'(frac_bcd_1), 32'h8);
    check("n1_int_bcd", int_bcd_1, 32'h00000007);
    @(negedge clk); out_ready_1 = 1'b1;
    @(posedge clk); #1;
    check("n1_in_ready", 32'(in_ready_1), 32'd1);
    out_ready_1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
